// File: rtl/rs_alu_station.sv
// ALU reservation station: buffers RS_DEPTH integer/branch ops, snoops N_CDB result buses
// for operand wakeup, issues one ready entry per cycle to a single-cycle ALU and broadcasts
// the registered result.
// Optional feature macro: RS_OLDEST_FIRST_EN (age-matrix oldest-first issue). When it is
// undefined, the lowest-index eligible entry issues.
// Opcode values mirror the shared define header, LUI (1) .. AND (29).
module rs_alu_station #(
  parameter int unsigned RS_DEPTH = 16,
  parameter int unsigned ROB_ID_W = 4,
  parameter int unsigned N_CDB    = 2,
  parameter int unsigned XLEN     = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      rdy_i,
  input  logic                      dsp_valid_i,
  input  logic [5:0]                dsp_op_i,
  input  logic [XLEN-1:0]           dsp_pc_i,
  input  logic [XLEN-1:0]           dsp_vj_i,
  input  logic [XLEN-1:0]           dsp_vk_i,
  input  logic                      dsp_qj_busy_i,
  input  logic                      dsp_qk_busy_i,
  input  logic [ROB_ID_W-1:0]       dsp_qj_i,
  input  logic [ROB_ID_W-1:0]       dsp_qk_i,
  input  logic [ROB_ID_W-1:0]       dsp_rob_id_i,
  input  logic [XLEN-1:0]           dsp_imm_i,
  input  logic [N_CDB-1:0]          cdb_valid_i,
  input  logic [N_CDB*ROB_ID_W-1:0] cdb_rob_id_i,
  input  logic [N_CDB*XLEN-1:0]     cdb_value_i,
  input  logic                      flush_i,
  output logic                      full_o,
  output logic                      out_valid_o,
  output logic [ROB_ID_W-1:0]       out_rob_id_o,
  output logic [XLEN-1:0]           out_value_o,
  output logic                      out_jump_o,
  output logic [XLEN-1:0]           out_pc_next_o
);

  localparam int unsigned IdxW = $clog2(RS_DEPTH);
  localparam int unsigned CntW = $clog2(RS_DEPTH) + 1;

  localparam logic [5:0] OpLui  = 6'd1,  OpAuipc = 6'd2,  OpJal  = 6'd3,  OpJalr = 6'd4;
  localparam logic [5:0] OpBeq  = 6'd5,  OpBne   = 6'd6,  OpBlt  = 6'd7,  OpBge  = 6'd8;
  localparam logic [5:0] OpBltu = 6'd9,  OpBgeu  = 6'd10, OpAddi = 6'd11, OpSlti = 6'd12;
  localparam logic [5:0] OpSltiu = 6'd13, OpXori = 6'd14, OpOri  = 6'd15, OpAndi = 6'd16;
  localparam logic [5:0] OpSlli = 6'd17, OpSrli  = 6'd18, OpSrai = 6'd19, OpAdd  = 6'd20;
  localparam logic [5:0] OpSub  = 6'd21, OpSll   = 6'd22, OpSlt  = 6'd23, OpSltu = 6'd24;
  localparam logic [5:0] OpXor  = 6'd25, OpSrl   = 6'd26, OpSra  = 6'd27, OpOr   = 6'd28;
  localparam logic [5:0] OpAnd  = 6'd29;

  // Entry state; only busy is reset, payload is qualified by busy.
  logic [RS_DEPTH-1:0] busy_q, busy_d;
  logic [5:0]          op_q  [RS_DEPTH];
  logic [XLEN-1:0]     pc_q  [RS_DEPTH];
  logic [XLEN-1:0]     imm_q [RS_DEPTH];
  logic [XLEN-1:0]     vj_q  [RS_DEPTH];
  logic [XLEN-1:0]     vk_q  [RS_DEPTH];
  logic [ROB_ID_W-1:0] rob_q [RS_DEPTH];
  logic [ROB_ID_W-1:0] qj_q  [RS_DEPTH];
  logic [ROB_ID_W-1:0] qk_q  [RS_DEPTH];
  logic [RS_DEPTH-1:0] qj_busy_q, qk_busy_q;

  logic                full_q;
  logic                out_valid_q, out_jump_q;
  logic [ROB_ID_W-1:0] out_rob_q;
  logic [XLEN-1:0]     out_value_q, out_pc_next_q;

  // {hit, value} of the lowest-numbered bus broadcasting tag.
  function automatic logic [XLEN:0] cdb_match(input logic [ROB_ID_W-1:0]       tag,
                                              input logic [N_CDB-1:0]          vld,
                                              input logic [N_CDB*ROB_ID_W-1:0] tags,
                                              input logic [N_CDB*XLEN-1:0]     vals);
    logic [XLEN:0] res;
    res = '0;
    for (int b = N_CDB - 1; b >= 0; b--) begin
      if (vld[b] && tags[b*ROB_ID_W +: ROB_ID_W] == tag) res = {1'b1, vals[b*XLEN +: XLEN]};
    end
    return res;
  endfunction

  logic [RS_DEPTH-1:0] wj_hit, wk_hit;
  logic [XLEN-1:0]     wj_val [RS_DEPTH];
  logic [XLEN-1:0]     wk_val [RS_DEPTH];
  logic                dj_hit, dk_hit;
  logic [XLEN-1:0]     dj_val, dk_val;

  // CDB snoop for stored pending operands and for the dispatch-cycle operands.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      {wj_hit[i], wj_val[i]} = cdb_match(qj_q[i], cdb_valid_i, cdb_rob_id_i, cdb_value_i);
      {wk_hit[i], wk_val[i]} = cdb_match(qk_q[i], cdb_valid_i, cdb_rob_id_i, cdb_value_i);
    end
    {dj_hit, dj_val} = cdb_match(dsp_qj_i, cdb_valid_i, cdb_rob_id_i, cdb_value_i);
    {dk_hit, dk_val} = cdb_match(dsp_qk_i, cdb_valid_i, cdb_rob_id_i, cdb_value_i);
  end

  logic            free_found, alloc;
  logic [IdxW-1:0] free_idx;

  // Lowest free slot, judged on registered busy so a slot freed now is reusable next edge.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!busy_q[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = IdxW'(i);
      end
    end
  end

  assign alloc = dsp_valid_i && free_found && !flush_i;

  logic [RS_DEPTH-1:0] elig, cand;
  assign elig = busy_q & ~qj_busy_q & ~qk_busy_q;

`ifdef RS_OLDEST_FIRST_EN
  // age_q[r][c] set: entry c was dispatched after entry r.
  logic [RS_DEPTH-1:0][RS_DEPTH-1:0] age_q;

  // Keep only eligible entries with no older eligible entry.
  always_comb begin
    for (int i = 0; i < RS_DEPTH; i++) begin
      cand[i] = elig[i];
      for (int j = 0; j < RS_DEPTH; j++) begin
        if (j != i && elig[j] && age_q[j][i]) cand[i] = 1'b0;
      end
    end
  end

  // Age matrix: new row cleared, new column marked in every live row.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      age_q <= '0;
    end else if (rdy_i) begin
      if (flush_i) begin
        age_q <= '0;
      end else if (alloc) begin
        for (int r = 0; r < RS_DEPTH; r++) begin
          if (IdxW'(r) == free_idx) age_q[r] <= '0;
          else if (busy_q[r])       age_q[r][free_idx] <= 1'b1;
        end
      end
    end
  end
`else
  assign cand = elig;
`endif

  logic            iss_valid;
  logic [IdxW-1:0] iss_idx;

  // Pick the lowest-index candidate (at most one under oldest-first).
  always_comb begin
    iss_valid = 1'b0;
    iss_idx   = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (cand[i] && !iss_valid) begin
        iss_valid = 1'b1;
        iss_idx   = IdxW'(i);
      end
    end
  end

  logic [XLEN-1:0] a, b, imm, pc, pc4, alu_value, alu_pc_next;
  logic [4:0]      sh_r, sh_i;
  logic            alu_jump, taken, is_branch;
  assign a    = vj_q[iss_idx];
  assign b    = vk_q[iss_idx];
  assign imm  = imm_q[iss_idx];
  assign pc   = pc_q[iss_idx];
  assign pc4  = pc + XLEN'(4);
  assign sh_r = b[4:0];
  assign sh_i = imm[4:0];

  // Single-cycle ALU on the selected entry.
  always_comb begin
    alu_value = '0;
    taken     = 1'b0;
    is_branch = 1'b0;
    alu_jump  = 1'b0;
    case (op_q[iss_idx])
      OpLui:   alu_value = imm;
      OpAuipc: alu_value = pc + imm;
      OpJal:   begin alu_value = pc4; alu_jump = 1'b1; end
      OpJalr:  begin alu_value = pc4; alu_jump = 1'b1; end
      OpBeq:   begin is_branch = 1'b1; taken = (a == b); end
      OpBne:   begin is_branch = 1'b1; taken = (a != b); end
      OpBlt:   begin is_branch = 1'b1; taken = ($signed(a) < $signed(b)); end
      OpBge:   begin is_branch = 1'b1; taken = ($signed(a) >= $signed(b)); end
      OpBltu:  begin is_branch = 1'b1; taken = (a < b); end
      OpBgeu:  begin is_branch = 1'b1; taken = (a >= b); end
      OpAddi:  alu_value = a + imm;
      OpSlti:  alu_value = {{(XLEN-1){1'b0}}, $signed(a) < $signed(imm)};
      OpSltiu: alu_value = {{(XLEN-1){1'b0}}, a < imm};
      OpXori:  alu_value = a ^ imm;
      OpOri:   alu_value = a | imm;
      OpAndi:  alu_value = a & imm;
      OpSlli:  alu_value = a << sh_i;
      OpSrli:  alu_value = a >> sh_i;
      OpSrai:  alu_value = $unsigned($signed(a) >>> sh_i);
      OpAdd:   alu_value = a + b;
      OpSub:   alu_value = a - b;
      OpSll:   alu_value = a << sh_r;
      OpSlt:   alu_value = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      OpSltu:  alu_value = {{(XLEN-1){1'b0}}, a < b};
      OpXor:   alu_value = a ^ b;
      OpSrl:   alu_value = a >> sh_r;
      OpSra:   alu_value = $unsigned($signed(a) >>> sh_r);
      OpOr:    alu_value = a | b;
      OpAnd:   alu_value = a & b;
      default: alu_value = '0;
    endcase
    if (is_branch) alu_jump = taken;
    if (op_q[iss_idx] == OpJalr)                alu_pc_next = (a + imm) & ~XLEN'(1);
    else if (op_q[iss_idx] == OpJal || taken)   alu_pc_next = pc + imm;
    else                                        alu_pc_next = pc4;
  end

  logic [CntW-1:0] busy_cnt;

  // Busy next-state (flush > issue > dispatch) and the post-edge occupancy count.
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (iss_valid) busy_d[iss_idx] = 1'b0;
      if (alloc)     busy_d[free_idx] = 1'b1;
    end
    busy_cnt = '0;
    for (int i = 0; i < RS_DEPTH; i++) busy_cnt = busy_cnt + CntW'(busy_d[i]);
  end

  // Control state and registered result broadcast.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      busy_q        <= '0;
      full_q        <= 1'b0;
      out_valid_q   <= 1'b0;
      out_rob_q     <= '0;
      out_value_q   <= '0;
      out_jump_q    <= 1'b0;
      out_pc_next_q <= '0;
    end else if (rdy_i) begin
      busy_q      <= busy_d;
      full_q      <= (busy_cnt >= CntW'(RS_DEPTH - 1));
      out_valid_q <= iss_valid && !flush_i;
      if (iss_valid && !flush_i) begin
        out_rob_q     <= rob_q[iss_idx];
        out_value_q   <= alu_value;
        out_jump_q    <= alu_jump;
        out_pc_next_q <= alu_pc_next;
      end
    end
  end

  // Entry payload: allocation with same-cycle forwarding, otherwise CDB wakeup.
  always_ff @(posedge clk_i) begin
    if (rdy_i) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (alloc && free_idx == IdxW'(i)) begin
          op_q[i]      <= dsp_op_i;
          pc_q[i]      <= dsp_pc_i;
          imm_q[i]     <= dsp_imm_i;
          rob_q[i]     <= dsp_rob_id_i;
          qj_q[i]      <= dsp_qj_i;
          qk_q[i]      <= dsp_qk_i;
          qj_busy_q[i] <= dsp_qj_busy_i && !dj_hit;
          qk_busy_q[i] <= dsp_qk_busy_i && !dk_hit;
          vj_q[i]      <= (dsp_qj_busy_i && dj_hit) ? dj_val : dsp_vj_i;
          vk_q[i]      <= (dsp_qk_busy_i && dk_hit) ? dk_val : dsp_vk_i;
        end else if (busy_q[i]) begin
          if (qj_busy_q[i] && wj_hit[i]) begin
            qj_busy_q[i] <= 1'b0;
            vj_q[i]      <= wj_val[i];
          end
          if (qk_busy_q[i] && wk_hit[i]) begin
            qk_busy_q[i] <= 1'b0;
            vk_q[i]      <= wk_val[i];
          end
        end
      end
    end
  end

  assign full_o        = full_q;
  assign out_valid_o   = out_valid_q;
  assign out_rob_id_o  = out_rob_q;
  assign out_value_o   = out_value_q;
  assign out_jump_o    = out_jump_q;
  assign out_pc_next_o = out_pc_next_q;

endmodule
